// File: rtl/sram_bank_pkg.sv
// Shared types and helpers for the round-robin arbitrated SRAM bank.
// Widths are fixed here so the request struct stays a simple packed type.
package sram_bank_pkg;

    localparam int unsigned CHANNEL    = 8;
    localparam int unsigned CH_WIDTH   = $clog2(CHANNEL);
    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned BE_WIDTH   = DATA_WIDTH / 8;
    localparam int unsigned MEM_DEPTH  = 2048;
    localparam int unsigned ADDR_WIDTH = $clog2(MEM_DEPTH);
    localparam int unsigned RD_LAT     = 2;

    typedef struct packed {
        logic                  wr;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
        logic [BE_WIDTH-1:0]   be;
    } sram_req_t;

    typedef struct packed {
        logic                found;
        logic [CH_WIDTH-1:0] idx;
    } rr_pick_t;

    // First valid channel searching ptr, ptr+1, ... wrapping at CHANNEL.
    function automatic rr_pick_t rr_pick(input logic [CHANNEL-1:0]  vld,
                                         input logic [CH_WIDTH-1:0] ptr);
        rr_pick_t            res;
        int unsigned         c;
        logic [CH_WIDTH-1:0] ci;
        res = '0;
        for (int unsigned k = 0; k < CHANNEL; k++) begin
            c  = (32'(ptr) + k) % CHANNEL;
            ci = CH_WIDTH'(c);
            if (!res.found && vld[ci]) begin
                res.found = 1'b1;
                res.idx   = ci;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/sram_sp_be.sv
// Single-port byte-enable SRAM array with an RdLat-stage read data pipe.
// Out-of-range writes are dropped and out-of-range reads return zero.
module sram_sp_be
    import sram_bank_pkg::*;
#(
    parameter int unsigned RdLat = RD_LAT
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [BE_WIDTH-1:0]   be_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q  [MEM_DEPTH];
    logic [DATA_WIDTH-1:0] pipe_q [RdLat];
    logic                  in_range;
    logic [DATA_WIDTH-1:0] rd_word;

    if (MEM_DEPTH == (2 ** ADDR_WIDTH)) begin : g_full_range
        assign in_range = 1'b1;
    end else begin : g_part_range
        assign in_range = addr_i < ADDR_WIDTH'(MEM_DEPTH);
    end

    assign rd_word = in_range ? mem_q[addr_i] : '0;

    // Array contents are intentionally not reset.
    always_ff @(posedge clk_i) begin
        if (en_i && we_i && in_range) begin
            for (int b = 0; b < BE_WIDTH; b++) begin
                if (be_i[b]) begin
                    mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < RdLat; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            if (en_i && !we_i) begin
                pipe_q[0] <= rd_word;
            end
            for (int i = 1; i < RdLat; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign rdata_o = pipe_q[RdLat-1];

endmodule

// File: rtl/sram_bank_rr_arb.sv
// SRAM bank shared by CHANNEL requesters: round-robin grant, byte-enable writes,
// fixed-latency read return tagged with the owning channel.
module sram_bank_rr_arb
    import sram_bank_pkg::*;
#(
    parameter int unsigned RdLat = RD_LAT
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [CHANNEL-1:0]               req_vld_i,
    output logic [CHANNEL-1:0]               req_rdy_o,
    input  logic [CHANNEL-1:0]               req_wr_i,
    input  logic [CHANNEL*ADDR_WIDTH-1:0]    req_addr_i,
    input  logic [CHANNEL*DATA_WIDTH-1:0]    req_wdata_i,
    input  logic [CHANNEL*BE_WIDTH-1:0]      req_be_i,
    output logic [CHANNEL-1:0]               rsp_vld_o,
    output logic [CH_WIDTH-1:0]              rsp_ch_o,
    output logic [DATA_WIDTH-1:0]            rsp_data_o,
    output logic [CH_WIDTH-1:0]              rr_ptr_o
);

    rr_pick_t              pick;
    sram_req_t             gnt_req;
    logic                  accept;
    logic [CH_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
    logic [RdLat-1:0]      vld_q;
    logic [CH_WIDTH-1:0]   ch_q [RdLat];
    logic [DATA_WIDTH-1:0] data_hold_q;
    logic [CH_WIDTH-1:0]   ch_hold_q;
    logic [DATA_WIDTH-1:0] rdata;

    always_comb begin
        pick      = rr_pick(req_vld_i, rr_ptr_q);
        accept    = pick.found;
        req_rdy_o = '0;
        if (accept) begin
            req_rdy_o[pick.idx] = 1'b1;
        end
        gnt_req.wr    = req_wr_i[pick.idx];
        gnt_req.addr  = req_addr_i[pick.idx*ADDR_WIDTH +: ADDR_WIDTH];
        gnt_req.wdata = req_wdata_i[pick.idx*DATA_WIDTH +: DATA_WIDTH];
        gnt_req.be    = req_be_i[pick.idx*BE_WIDTH +: BE_WIDTH];
        rr_ptr_d      = rr_ptr_q;
        if (accept) begin
            rr_ptr_d = (pick.idx == CH_WIDTH'(CHANNEL - 1)) ? '0 : pick.idx + 1'b1;
        end
    end

    sram_sp_be #(
        .RdLat (RdLat)
    ) u_array (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .en_i    (accept),
        .we_i    (gnt_req.wr),
        .addr_i  (gnt_req.addr),
        .wdata_i (gnt_req.wdata),
        .be_i    (gnt_req.be),
        .rdata_o (rdata)
    );

    // Valid/tag pipe runs in lockstep with the array's data pipe.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr_q    <= '0;
            vld_q       <= '0;
            data_hold_q <= '0;
            ch_hold_q   <= '0;
            for (int i = 0; i < RdLat; i++) begin
                ch_q[i] <= '0;
            end
        end else begin
            rr_ptr_q <= rr_ptr_d;
            vld_q[0] <= accept & ~gnt_req.wr;
            ch_q[0]  <= pick.idx;
            for (int i = 1; i < RdLat; i++) begin
                vld_q[i] <= vld_q[i-1];
                ch_q[i]  <= ch_q[i-1];
            end
            if (vld_q[RdLat-1]) begin
                data_hold_q <= rdata;
                ch_hold_q   <= ch_q[RdLat-1];
            end
        end
    end

    always_comb begin
        rsp_vld_o  = '0;
        rsp_ch_o   = ch_hold_q;
        rsp_data_o = data_hold_q;
        if (vld_q[RdLat-1]) begin
            rsp_vld_o[ch_q[RdLat-1]] = 1'b1;
            rsp_ch_o                 = ch_q[RdLat-1];
            rsp_data_o               = rdata;
        end
    end

    assign rr_ptr_o = rr_ptr_q;

endmodule

// File: tb/tb_sram_bank_rr_arb.sv
// Randomised and directed bench for sram_bank_rr_arb against a transaction-level model.
module tb_sram_bank_rr_arb;
    import sram_bank_pkg::*;

    localparam int NCH = CHANNEL;
    localparam int LAT = RD_LAT;

    logic                          clk_i = 1'b0;
    logic                          rst_i = 1'b1;
    logic [NCH-1:0]                req_vld_i, req_rdy_o, req_wr_i, rsp_vld_o;
    logic [NCH*ADDR_WIDTH-1:0]     req_addr_i;
    logic [NCH*DATA_WIDTH-1:0]     req_wdata_i;
    logic [NCH*BE_WIDTH-1:0]       req_be_i;
    logic [CH_WIDTH-1:0]           rsp_ch_o, rr_ptr_o;
    logic [DATA_WIDTH-1:0]         rsp_data_o;

    logic                  vld_a   [NCH];
    logic                  wr_a    [NCH];
    logic [ADDR_WIDTH-1:0] addr_a  [NCH];
    logic [DATA_WIDTH-1:0] wdata_a [NCH];
    logic [BE_WIDTH-1:0]   be_a    [NCH];

    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            req_vld_i[c]                            = vld_a[c];
            req_wr_i[c]                             = wr_a[c];
            req_addr_i[c*ADDR_WIDTH +: ADDR_WIDTH]  = addr_a[c];
            req_wdata_i[c*DATA_WIDTH +: DATA_WIDTH] = wdata_a[c];
            req_be_i[c*BE_WIDTH +: BE_WIDTH]        = be_a[c];
        end
    end

    sram_bank_rr_arb #(
        .RdLat (LAT)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_vld_i   (req_vld_i),
        .req_rdy_o   (req_rdy_o),
        .req_wr_i    (req_wr_i),
        .req_addr_i  (req_addr_i),
        .req_wdata_i (req_wdata_i),
        .req_be_i    (req_be_i),
        .rsp_vld_o   (rsp_vld_o),
        .rsp_ch_o    (rsp_ch_o),
        .rsp_data_o  (rsp_data_o),
        .rr_ptr_o    (rr_ptr_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int          due;
        int          ch;
        logic [31:0] data;
        bit          known;
    } exp_t;

    exp_t        rsp_q [$];
    logic [31:0] mem_m   [MEM_DEPTH];
    bit          known_m [MEM_DEPTH];
    int          ptr_m;
    int          cyc;
    logic [31:0] last_data;
    bit          last_known;
    int          last_ch;
    int          n_checks;
    int          n_fail;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int model_grant();
        for (int k = 0; k < NCH; k++) begin
            if (vld_a[(ptr_m + k) % NCH]) return (ptr_m + k) % NCH;
        end
        return -1;
    endfunction

    task automatic model_reset();
        rsp_q.delete();
        ptr_m      = 0;
        last_data  = '0;
        last_known = 1'b1;
        last_ch    = 0;
    endtask

    task automatic clear_reqs();
        for (int c = 0; c < NCH; c++) begin
            vld_a[c] = 1'b0; wr_a[c] = 1'b0; addr_a[c] = '0; wdata_a[c] = '0; be_a[c] = '0;
        end
    endtask

    task automatic set_req(input int c, input bit wr, input int addr, input logic [31:0] d,
                           input logic [3:0] be);
        vld_a[c] = 1'b1; wr_a[c] = wr; addr_a[c] = ADDR_WIDTH'(addr); wdata_a[c] = d; be_a[c] = be;
    endtask

    // One clock: check grant, update model, advance, check pointer and response bus.
    task automatic step();
        int   g;
        exp_t e;
        #1;
        g = model_grant();
        check_eq("rdy", req_rdy_o, (g >= 0) ? (64'd1 << g) : 64'd0);
        if (g >= 0) begin
            if (wr_a[g]) begin
                for (int b = 0; b < 4; b++) begin
                    if (be_a[g][b]) mem_m[addr_a[g]][b*8 +: 8] = wdata_a[g][b*8 +: 8];
                end
                if (be_a[g] == 4'hF) known_m[addr_a[g]] = 1'b1;
            end else begin
                e.due = cyc + LAT; e.ch = g;
                e.data = mem_m[addr_a[g]]; e.known = known_m[addr_a[g]];
                rsp_q.push_back(e);
            end
            ptr_m = (g == NCH - 1) ? 0 : g + 1;
        end
        @(posedge clk_i);
        cyc++;
        #1;
        check_eq("rr_ptr", rr_ptr_o, ptr_m);
        if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
            e = rsp_q.pop_front();
            check_eq("rsp_vld", rsp_vld_o, 64'd1 << e.ch);
            check_eq("rsp_ch", rsp_ch_o, e.ch);
            if (e.known) check_eq("rsp_data", rsp_data_o, e.data);
            last_ch = e.ch; last_data = e.data; last_known = e.known;
        end else begin
            check_eq("rsp_idle_vld", rsp_vld_o, 0);
            check_eq("rsp_hold_ch", rsp_ch_o, last_ch);
            if (last_known) check_eq("rsp_hold_data", rsp_data_o, last_data);
        end
    endtask

    initial begin
        n_checks = 0; n_fail = 0; cyc = 0;
        for (int a = 0; a < MEM_DEPTH; a++) known_m[a] = 1'b0;
        model_reset();
        clear_reqs();

        // Reset held with every channel requesting.
        for (int c = 0; c < NCH; c++) set_req(c, 1'b0, c, 0, 0);
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;
        #1;
        check_eq("rst_rdy", req_rdy_o, 8'h01);
        check_eq("rst_rsp_vld", rsp_vld_o, 0);
        check_eq("rst_ptr", rr_ptr_o, 0);

        // Fairness: all channels reading.
        for (int i = 0; i < 16; i++) begin
            check_eq("fair_gnt", req_rdy_o, 64'd1 << (i % NCH));
            step();
        end
        clear_reqs();
        repeat (LAT) step();

        // Byte-enable merge on ch3.
        set_req(3, 1'b1, 5, 32'hAABBCCDD, 4'hF); step();
        set_req(3, 1'b1, 5, 32'h11223344, 4'h5); step();
        set_req(3, 1'b0, 5, 0, 4'h0);             step();
        clear_reqs(); repeat (LAT - 1) step();
        check_eq("be_data", rsp_data_o, 32'hAA22CC44);
        check_eq("be_ch", rsp_ch_o, 3);

        // Write then read of the top address on the next cycle.
        set_req(1, 1'b1, 2047, 32'hDEADBEEF, 4'hF); step();
        clear_reqs();
        set_req(2, 1'b0, 2047, 0, 4'h0); step();
        clear_reqs(); repeat (LAT - 1) step();
        check_eq("b2b_vld", rsp_vld_o, 8'h04);
        check_eq("b2b_data", rsp_data_o, 32'hDEADBEEF);
        step();

        // Skip and wrap from rr_ptr=6.
        set_req(5, 1'b0, 0, 0, 0); step();
        clear_reqs();
        check_eq("wrap_ptr6", rr_ptr_o, 6);
        set_req(1, 1'b0, 1, 0, 0); set_req(7, 1'b0, 7, 0, 0);
        #1 check_eq("wrap_gnt7", req_rdy_o, 8'h80);
        step();
        check_eq("wrap_ptr0", rr_ptr_o, 0);
        check_eq("wrap_gnt1", req_rdy_o, 8'h02);
        step();
        check_eq("wrap_ptr2", rr_ptr_o, 2);
        clear_reqs(); repeat (LAT + 1) step();

        // Prime addresses 0..15 with full words for the random phase.
        for (int a = 0; a < 16; a++) begin
            set_req(0, 1'b1, a, $urandom, 4'hF); step();
        end
        clear_reqs();

        // Randomised mix with heavy address reuse.
        for (int i = 0; i < 400; i++) begin
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(0, 2) == 0) set_req(c, $urandom_range(0, 1) == 1,
                    $urandom_range(0, 15), $urandom, 4'($urandom_range(0, 15)));
                else vld_a[c] = 1'b0;
            end
            step();
        end
        clear_reqs(); repeat (LAT + 1) step();

        // Reset during an in-flight read; earlier write must survive.
        set_req(0, 1'b1, 9, 32'h5A5A_1234, 4'hF); step();
        set_req(0, 1'b0, 9, 0, 4'h0); step();
        clear_reqs();
        rst_i = 1'b1;
        model_reset();
        #1 check_eq("rst_mid_vld", rsp_vld_o, 0);
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
        repeat (4) step();
        set_req(4, 1'b0, 9, 0, 4'h0); step();
        clear_reqs(); repeat (LAT - 1) step();
        check_eq("rst_keep_data", rsp_data_o, 32'h5A5A_1234);
        check_eq("rst_keep_vld", rsp_vld_o, 8'h10);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
